// File: rtl/rom_arb_pkg.sv
// Shared constants, port-select encoding and the address range check for rom_arb.
package rom_arb_pkg;

  localparam int ROM_WORDS_DEF  = 4096;
  localparam int STARVE_MAX_DEF = 4;
  localparam int CNT_W          = 3;
  localparam int NUM_PORTS      = 2;
  localparam int DATA_W         = 32;
  localparam int WIDX_LSB       = 2;    // word index is addr[31:2]
  localparam int WIDX_W         = 30;

  typedef enum logic [1:0] {
    SEL_NONE = 2'd0,
    SEL_M0   = 2'd1,
    SEL_M1   = 2'd2
  } sel_e;

  // Registered response of one port.
  typedef struct packed {
    logic              vld;
    logic [DATA_W-1:0] data;
    logic              err;
  } rsp_t;

  // An access errors when it is misaligned or its word index is past the ROM end.
  function automatic logic addr_err(input logic [31:0] addr, input int words);
    logic [31:0] widx;
    widx = {2'b00, addr[31:WIDX_LSB]};
    return (widx >= 32'(words)) || (addr[WIDX_LSB-1:0] != 2'b00);
  endfunction

endpackage

// File: rtl/rom_arb_prio.sv
// Two-input fixed-priority arbiter: port 1 wins by default, port 0 is forced
// through after STARVE_MAX consecutive lost cycles.
module rom_arb_prio
  import rom_arb_pkg::*;
#(
  parameter int STARVE_MAX = STARVE_MAX_DEF
) (
  input  logic clk,
  input  logic rst,
  input  logic req0,
  input  logic req1,
  output sel_e sel
);

  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STARVE_MAX);

  logic [CNT_W-1:0] starve_cnt, cnt_nxt;
  logic             force0;

  assign force0 = req0 && (starve_cnt == CNT_MAX);

  // Starvation counter register.
  always_ff @(posedge clk) begin
    if (rst) starve_cnt <= '0;
    else     starve_cnt <= cnt_nxt;
  end

  // Count lost cycles while port 0 waits; any win or dropped request clears it.
  always_comb begin
    cnt_nxt = starve_cnt;
    if (!req0 || sel == SEL_M0) cnt_nxt = '0;
    else if (starve_cnt != CNT_MAX) cnt_nxt = starve_cnt + 1'b1;
  end

  // Grant select; nothing is granted while in reset.
  always_comb begin
    sel = SEL_NONE;
    if (!rst) begin
      if (force0)    sel = SEL_M0;
      else if (req1) sel = SEL_M1;
      else if (req0) sel = SEL_M0;
    end
  end

endmodule

// File: rtl/rom_arb.sv
// Two-port arbiter in front of a shared combinational ROM, one-cycle read latency.
module rom_arb
  import rom_arb_pkg::*;
#(
  parameter int STARVE_MAX = STARVE_MAX_DEF,
  parameter int ROM_WORDS  = ROM_WORDS_DEF
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        m0_req,
  input  logic [31:0] m0_addr,
  output logic        m0_gnt,
  output logic        m0_rvalid,
  output logic [31:0] m0_rdata,
  output logic        m0_err,
  input  logic        m1_req,
  input  logic [31:0] m1_addr,
  output logic        m1_gnt,
  output logic        m1_rvalid,
  output logic [31:0] m1_rdata,
  output logic        m1_err,
  output logic        rom_en,
  output logic [31:0] rom_addr,
  input  logic [31:0] rom_data
);

  sel_e                 sel;
  logic [NUM_PORTS-1:0] gnt;
  logic [31:0]          g_addr;
  logic                 g_err;
  rsp_t [NUM_PORTS-1:0] rsp_q;

  rom_arb_prio #(.STARVE_MAX(STARVE_MAX)) u_prio (
    .clk  (clk),
    .rst  (rst),
    .req0 (m0_req),
    .req1 (m1_req),
    .sel  (sel)
  );

  // Mux the winner onto the ROM; errored or idle cycles keep the ROM quiet.
  always_comb begin
    gnt      = {sel == SEL_M1, sel == SEL_M0};
    g_addr   = gnt[1] ? m1_addr : m0_addr;
    g_err    = addr_err(g_addr, ROM_WORDS);
    rom_en   = (|gnt) && !g_err;
    rom_addr = rom_en ? g_addr : 32'h0;
  end

  // Capture the response for the granted port only; all others read back zero.
  always_ff @(posedge clk) begin
    if (rst) begin
      rsp_q <= '0;
    end else begin
      for (int p = 0; p < NUM_PORTS; p++) begin
        rsp_q[p].vld  <= gnt[p];
        rsp_q[p].data <= (gnt[p] && !g_err) ? rom_data : '0;
        rsp_q[p].err  <= gnt[p] && g_err;
      end
    end
  end

  assign m0_gnt    = gnt[0];
  assign m1_gnt    = gnt[1];
  assign m0_rvalid = rsp_q[0].vld;
  assign m0_rdata  = rsp_q[0].data;
  assign m0_err    = rsp_q[0].err;
  assign m1_rvalid = rsp_q[1].vld;
  assign m1_rdata  = rsp_q[1].data;
  assign m1_err    = rsp_q[1].err;

endmodule

// File: tb/tb_rom_arb.sv
// Scoreboard bench for rom_arb: directed cases then a long random run.
module tb_rom_arb;

  localparam int SM    = 4;
  localparam int WORDS = 4096;

  logic        clk = 1'b0;
  logic        rst;
  logic        m0_req, m1_req;
  logic [31:0] m0_addr, m1_addr;
  logic        m0_gnt, m0_rvalid, m0_err, m1_gnt, m1_rvalid, m1_err;
  logic [31:0] m0_rdata, m1_rdata;
  logic        rom_en;
  logic [31:0] rom_addr, rom_data;

  int checks = 0;
  int errors = 0;

  typedef struct {
    bit          port;
    logic [31:0] data;
    logic        err;
  } exp_t;

  exp_t sb[$];
  int   m_cnt = 0;   // model: consecutive cycles port 0 lost
  int   loss  = 0;   // observed consecutive port-0 losses

  always #5 clk = ~clk;

  rom_arb #(.STARVE_MAX(SM), .ROM_WORDS(WORDS)) dut (
    .clk(clk), .rst(rst),
    .m0_req(m0_req), .m0_addr(m0_addr), .m0_gnt(m0_gnt),
    .m0_rvalid(m0_rvalid), .m0_rdata(m0_rdata), .m0_err(m0_err),
    .m1_req(m1_req), .m1_addr(m1_addr), .m1_gnt(m1_gnt),
    .m1_rvalid(m1_rvalid), .m1_rdata(m1_rdata), .m1_err(m1_err),
    .rom_en(rom_en), .rom_addr(rom_addr), .rom_data(rom_data)
  );

  function automatic logic [31:0] rom_word(input logic [29:0] idx);
    if (idx == 30'd4) return 32'h0010_0093;
    return (32'(idx) * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
  endfunction

  function automatic logic exp_err(input logic [31:0] a);
    return (a[31:2] >= 30'(WORDS)) || (a[1:0] != 2'b00);
  endfunction

  // ROM model; garbage when disabled so leaked data shows up.
  always_comb rom_data = rom_en ? rom_word(rom_addr[31:2]) : 32'hDEAD_BEEF;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h exp %h at %0t", tag, got, exp, $time);
    end
  endtask

  // One clock cycle: drive, then check the response of the last grant and this cycle's grant.
  task automatic cyc(input logic r, input logic q0, input logic [31:0] a0,
                     input logic q1, input logic [31:0] a1,
                     output logic eg0, output logic eg1);
    exp_t        e;
    logic [31:0] ga;
    @(posedge clk); #1;
    rst = r; m0_req = q0; m0_addr = a0; m1_req = q1; m1_addr = a1;
    @(negedge clk);
    if (sb.size() > 0) begin
      e = sb.pop_front();
      chk("m0_rvalid", m0_rvalid, e.port == 1'b0);
      chk("m1_rvalid", m1_rvalid, e.port == 1'b1);
      chk("m0_rdata",  m0_rdata, e.port == 1'b0 ? e.data : 32'h0);
      chk("m1_rdata",  m1_rdata, e.port == 1'b1 ? e.data : 32'h0);
      chk("m0_err",    m0_err, e.port == 1'b0 ? e.err : 1'b0);
      chk("m1_err",    m1_err, e.port == 1'b1 ? e.err : 1'b0);
    end else begin
      chk("idle_rsp", {m0_rvalid, m1_rvalid, m0_err, m1_err}, 0);
      chk("idle_rdata", m0_rdata | m1_rdata, 0);
    end
    eg0 = !r && q0 && (!q1 || m_cnt >= SM);
    eg1 = !r && q1 && !eg0;
    chk("m0_gnt", m0_gnt, eg0);
    chk("m1_gnt", m1_gnt, eg1);
    chk("one_gnt", m0_gnt & m1_gnt, 0);
    ga = eg1 ? a1 : a0;
    if (eg0 || eg1) begin
      chk("rom_en", rom_en, !exp_err(ga));
      chk("rom_addr", rom_addr, exp_err(ga) ? 32'h0 : ga);
      e.port = eg1;
      e.err  = exp_err(ga);
      e.data = e.err ? 32'h0 : rom_word(ga[31:2]);
      sb.push_back(e);
    end else begin
      chk("rom_idle", {rom_en, rom_addr}, 0);
    end
    if (r || !q0 || eg0) m_cnt = 0;
    else if (m_cnt < SM) m_cnt++;
    if (!r && m0_req && !m0_gnt) loss++;
    else loss = 0;
    chk("m0_starve", loss > SM, 0);
  endtask

  function automatic logic [31:0] rnd_addr();
    logic [31:0] a;
    a = {18'h0, 14'($urandom_range(0, 4200)) } << 2;
    if ($urandom_range(0, 7) == 0) a[1:0] = 2'($urandom_range(1, 3));
    return a;
  endfunction

  initial begin
    logic        g0, g1, p0, p1;
    logic [31:0] a0, a1;
    logic        pat [10];
    rst = 1'b1; m0_req = 0; m1_req = 0; m0_addr = 0; m1_addr = 0;

    // reset state
    cyc(1, 0, 0, 0, 0, g0, g1);
    cyc(1, 1, 32'h10, 1, 32'h20, g0, g1);
    // first cycle out of reset grants immediately
    cyc(0, 1, 32'h10, 0, 0, g0, g1);
    chk("first_gnt", m0_gnt, 1);
    cyc(0, 0, 0, 0, 0, g0, g1);
    chk("word4", m0_rdata, 32'h0010_0093);

    // starvation pattern: m1 x4, m0, m1 x4, m0
    pat = '{1, 1, 1, 1, 0, 1, 1, 1, 1, 0};
    for (int i = 0; i < 10; i++) begin
      cyc(0, 1, 32'h100, 1, 32'(i * 4), g0, g1);
      chk("starve_pat", m1_gnt, pat[i]);
    end
    cyc(0, 0, 0, 0, 0, g0, g1);

    // misaligned m1, out-of-range and last-word m0
    cyc(0, 0, 0, 1, 32'h6, g0, g1);
    chk("misalign_en", rom_en, 0);
    cyc(0, 1, 32'h4000, 0, 0, g0, g1);
    chk("misalign_err", m1_err, 1);
    cyc(0, 1, 32'h3FFC, 0, 0, g0, g1);
    chk("oor_err", m0_err, 1);
    cyc(0, 0, 0, 0, 0, g0, g1);
    chk("last_word", m0_rdata, rom_word(30'd4095));

    // reset during a grant cycle, then recovery
    cyc(0, 1, 32'h20, 0, 0, g0, g1);
    cyc(1, 0, 0, 1, 32'h24, g0, g1);
    cyc(0, 0, 0, 1, 32'h24, g0, g1);
    chk("post_rst_gnt", m1_gnt, 1);
    cyc(0, 0, 0, 0, 0, g0, g1);
    chk("post_rst_data", m1_rdata, rom_word(30'd9));

    // random traffic; requests held until granted, occasionally dropped
    p0 = 0; p1 = 0; a0 = 0; a1 = 0;
    for (int i = 0; i < 10000; i++) begin
      cyc(($urandom_range(0, 499) == 0), p0, a0, p1, a1, g0, g1);
      if (!p0 || g0 || $urandom_range(0, 15) == 0) begin
        p0 = ($urandom_range(0, 3) != 0); a0 = rnd_addr();
      end
      if (!p1 || g1 || $urandom_range(0, 15) == 0) begin
        p1 = ($urandom_range(0, 3) != 0); a1 = rnd_addr();
      end
    end
    cyc(0, 0, 0, 0, 0, g0, g1);
    cyc(0, 0, 0, 0, 0, g0, g1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
